// File: rtl/multicycle_shifter.sv
// Iterative shifter: SLL/SRL/SRA/ROR by shamt, at most STEP bits per clock.
// Area-reduced companion to the single-cycle execute ALU.
module multicycle_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [SHW:0]     rem_x;
  logic [SHW:0]     k;
  logic [SHW-1:0]   rem_left;
  logic [WIDTH-1:0] shifted;

  // k = min(rem, STEP); never exceeds rem, so rem cannot underflow
  always_comb begin
    rem_x    = {1'b0, rem_q};
    k        = (rem_x < STEP_K) ? rem_x : STEP_K;
    rem_left = rem_q - k[SHW-1:0];
  end

  always_comb begin
    shifted = acc_q;
    unique case (op_q)
      OP_SLL: shifted = acc_q << k;
      OP_SRL: shifted = acc_q >> k;
      OP_SRA: shifted = $unsigned($signed(acc_q) >>> k);
      OP_ROR: shifted = (acc_q >> k) | (acc_q << (WIDTH_K - k));
      default: shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = in_data;
          rem_d = shamt;
          op_d  = mode;
          if (shamt == '0) begin
            out_d   = in_data;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        rem_d = rem_left;
        if (rem_left == '0) begin
          out_d   = shifted;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign out_data = out_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed bench for multicycle_shifter (WIDTH=32, STEP=4).
// Latency counted from the edge that samples start.
module tb_multicycle_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_shifter #(
    .WIDTH(32),
    .SHW  (5),
    .STEP (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .in_data (in_data),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // lat = N+1; occupancy = start cycle + busy cycles = N+2
  task automatic run_op(input string tag,
                        input logic [1:0] m,
                        input logic [31:0] d,
                        input logic [4:0] s,
                        input logic [31:0] exp,
                        input int lat);
    int cyc;
    int bsy;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    in_data = d;
    shamt = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    bsy = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc++;
      if (busy) bsy++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_occ"}, 64'(bsy + 1), 64'(lat + 1));
    chk({tag, "_out"}, 64'(out_data), 64'(exp));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_hold"}, 64'(out_data), 64'(exp));
  endtask

  initial begin : main
    int dones;
    bit drop;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    in_data = '0;
    shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
    run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 2);
    run_op("sra0", 2'b10, 32'h0000_1234, 5'd0, 32'h0000_1234, 1);
    run_op("ror4", 2'b11, 32'h0000_000F, 5'd4, 32'hF000_0000, 2);
    run_op("ror9", 2'b11, 32'h1234_5678, 5'd9, 32'h3C09_1A2B, 4);
    run_op("sll31", 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 9);
    run_op("sra_pos", 2'b10, 32'h7000_0000, 5'd5, 32'h0380_0000, 3);

    // start held high with changing operands: only the first op runs
    @(negedge clk);
    start = 1'b1;
    mode = 2'b00;
    in_data = 32'h0000_0001;
    shamt = 5'd5;
    @(posedge clk);
    #1;
    dones = 0;
    drop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (drop) start = 1'b0;
      if (done) begin
        dones++;
        drop = 1'b1;
      end else if (!drop) begin
        in_data = in_data ^ 32'hA5A5_0000;
        mode = 2'b11;
        shamt = 5'd7;
      end
      @(posedge clk);
      #1;
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_out", 64'(out_data), 64'h20);
    chk("ign_busy", 64'(busy), 64'd0);

    // reset during the 2nd SHIFT cycle aborts the op
    @(negedge clk);
    start = 1'b1;
    mode = 2'b10;
    in_data = 32'h8000_0000;
    shamt = 5'd31;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", 64'(out_data), 64'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort_nodone", 64'(dones), 64'd0);

    // rst wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    mode = 2'b00;
    in_data = 32'h1;
    shamt = 5'd0;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", 64'(busy), 64'd0);
    chk("rst_prio_out", 64'(out_data), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
